// File: rtl/lvds_pkg.sv
// Shared types and constants for the 2-lane LVDS receive path.
// Optional build macro used by lvds_receiver: LVDS_RX_TRAIN_FILTER_EN.
package lvds_pkg;

    localparam int LANES         = 2;
    localparam int WORD_W        = 8;
    localparam int BITS_PER_LANE = 4;

    localparam logic [WORD_W-1:0] TRAIN_PATTERN_DEFAULT = 8'hC3;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/lvds_lane_deser.sv
// One LVDS lane: shifts in one bit per clock, MSB of the nibble arrives first.
module lvds_lane_deser
    import lvds_pkg::*;
(
    input  logic                     input_clk,
    input  logic                     arst,
    input  logic                     serial_bit,
    output logic [BITS_PER_LANE-1:0] nibble
);

    logic [BITS_PER_LANE-1:0] nibble_reg;

    always_ff @(posedge input_clk or posedge arst) begin
        if (arst) begin
            nibble_reg <= '0;
        end else begin
            nibble_reg <= {nibble_reg[BITS_PER_LANE-2:0], serial_bit};
        end
    end

    assign nibble = nibble_reg;

endmodule

// File: rtl/lvds_receiver.sv
// 2-lane LVDS deserializer with training-pattern word alignment.
// Build macro LVDS_RX_TRAIN_FILTER_EN: suppress training words once locked.
module lvds_receiver
    import lvds_pkg::*;
#(
    parameter logic [WORD_W-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEFAULT,
    parameter int                LOCK_COUNT    = 4
) (
    input  logic              input_clk,
    input  logic              arst,
    input  logic [LANES-1:0]  input_data,
    input  logic              resync,
    output logic [WORD_W-1:0] output_data,
    output logic              output_valid,
    output logic              locked
);

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    logic [BITS_PER_LANE-1:0] lane_sr [LANES];
    logic [WORD_W-1:0]        cand;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            lvds_lane_deser u_lane (
                .input_clk  (input_clk),
                .arst       (arst),
                .serial_bit (input_data[gi]),
                .nibble     (lane_sr[gi])
            );
        end
    endgenerate

    // Lane 1 holds the upper nibble of the word.
    assign cand = {lane_sr[1], lane_sr[0]};

    state_t            state_reg, state_next;
    logic [1:0]        phase_reg, phase_next;
    logic [3:0]        count_reg, count_next;
    logic [WORD_W-1:0] data_reg, data_next;
    logic              valid_reg, valid_next;

    logic boundary;
    logic match;
    logic deliver;

    assign boundary = (phase_reg == 2'd3);
    assign match    = (cand == TRAIN_PATTERN);

`ifdef LVDS_RX_TRAIN_FILTER_EN
    assign deliver = boundary && !match;
`else
    assign deliver = boundary;
`endif

    always_ff @(posedge input_clk or posedge arst) begin
        if (arst) begin
            state_reg <= HUNT;
            phase_reg <= 2'd0;
            count_reg <= 4'd0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            count_reg <= count_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg + 2'd1;
        count_next = count_reg;
        data_next  = data_reg;
        valid_next = 1'b0;

        if (resync) begin
            // Dropping lock wins over any boundary in the same cycle.
            state_next = HUNT;
            count_next = 4'd0;
        end else begin
            case (state_reg)
                HUNT: begin
                    if (match) begin
                        // The word just completed; the next edge starts a new word.
                        phase_next = 2'd0;
                        count_next = 4'd1;
                        state_next = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (boundary) begin
                        if (match) begin
                            count_next = count_reg + 4'd1;
                            if (count_reg + 4'd1 == LOCK_TARGET) begin
                                state_next = LOCKED;
                            end
                        end else begin
                            state_next = HUNT;
                            count_next = 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (deliver) begin
                        data_next  = cand;
                        valid_next = 1'b1;
                    end
                end
                default: begin
                    state_next = HUNT;
                    count_next = 4'd0;
                end
            endcase
        end
    end

    assign output_data  = data_reg;
    assign output_valid = valid_reg;
    assign locked       = (state_reg == LOCKED);

endmodule
